// File: rtl/mem_arbiter_if.sv
// Signal bundle between mem_arbiter, the CPU fetch/data ports and the shared main memory.
// The arbiter takes the slave view; the CPU-plus-memory side takes the master view.
interface mem_arbiter_if #(
    parameter int n      = 16,
    parameter int ADDR_W = 8
);
    logic              i_req;
    logic [n-1:0]      i_addr;
    logic [n-1:0]      i_rdata;
    logic              i_ack;
    logic              i_err;
    logic              d_req;
    logic              d_we;
    logic [n-1:0]      d_addr;
    logic [n-1:0]      d_wdata;
    logic [n-1:0]      d_rdata;
    logic              d_ack;
    logic              d_err;
    logic              stall;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [n-1:0]      mem_wdata;
    logic [n-1:0]      mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_rdata, i_ack, i_err, d_rdata, d_ack, d_err, stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_rdata, i_ack, i_err, d_rdata, d_ack, d_err, stall,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port main memory between the CPU fetch and data ports with req/ack
// handshakes, fixed read wait states, data-first arbitration and a fetch starvation guard.
module mem_arbiter #(
    parameter int n      = 16,
    parameter int ADDR_W = 8,
    parameter int WAIT   = 1,
    parameter int STARVE = 4
) (
    input logic          clk,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    localparam int OFF = $clog2(n / 8);
    localparam int HI  = OFF + ADDR_W;
    localparam logic [n-1:0] LOW_MASK  = (n'(1) << OFF) - n'(1);
    localparam logic [n-1:0] HIGH_MASK = (HI >= n) ? '0 : ~((n'(1) << HI) - n'(1));
    localparam int SW = $clog2(STARVE + 2);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE);
    localparam logic [3:0]    WAIT_C   = 4'(WAIT);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_portD;
    logic [3:0]        r_cnt;
    logic [SW-1:0]     r_starve;
    logic              r_memEn;
    logic              r_memWe;
    logic [ADDR_W-1:0] r_memAddr;
    logic [n-1:0]      r_memWdata;
    logic              r_iAck;
    logic              r_iErr;
    logic [n-1:0]      r_iRdata;
    logic              r_dAck;
    logic              r_dErr;
    logic [n-1:0]      r_dRdata;

    logic              w_grant;
    logic              w_grantD;
    logic              w_err;
    logic [n-1:0]      w_addr;

    // Arbitration and next state; the fetch port wins a tie only once the guard has saturated
    always_comb begin
        w_next   = r_state;
        w_grant  = 1'b0;
        w_grantD = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.d_req && !(bus.i_req && r_starve == STARVE_C)) begin
                    w_grant  = 1'b1;
                    w_grantD = 1'b1;
                end else if (bus.i_req) begin
                    w_grant = 1'b1;
                end
            end
            ST_BUSY: if (r_cnt == 4'd0) w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        w_addr = w_grantD ? bus.d_addr : bus.i_addr;
        w_err  = ((w_addr & LOW_MASK) != '0) || ((w_addr & HIGH_MASK) != '0);
        if (w_grant) w_next = w_err ? ST_RESP : ST_BUSY;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_portD    <= 1'b0;
            r_cnt      <= 4'd0;
            r_starve   <= '0;
            r_memEn    <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_iAck     <= 1'b0;
            r_iErr     <= 1'b0;
            r_iRdata   <= '0;
            r_dAck     <= 1'b0;
            r_dErr     <= 1'b0;
            r_dRdata   <= '0;
        end else begin
            r_state <= w_next;
            r_memEn <= 1'b0;
            r_memWe <= 1'b0;
            r_iAck  <= 1'b0;
            r_dAck  <= 1'b0;

            if (!bus.i_req || (w_grant && !w_grantD)) begin
                r_starve <= '0;
            end else if (w_grantD && r_starve != STARVE_C) begin
                r_starve <= r_starve + 1'b1;
            end

            // Bad addresses skip the memory entirely and answer on the next cycle
            if (w_grant) begin
                r_portD    <= w_grantD;
                r_cnt      <= WAIT_C;
                r_memAddr  <= ADDR_W'(w_addr >> OFF);
                r_memWdata <= bus.d_wdata;
                if (w_err) begin
                    if (w_grantD) begin
                        r_dAck   <= 1'b1;
                        r_dErr   <= 1'b1;
                        r_dRdata <= '0;
                    end else begin
                        r_iAck   <= 1'b1;
                        r_iErr   <= 1'b1;
                        r_iRdata <= '0;
                    end
                end else begin
                    r_memEn <= 1'b1;
                    r_memWe <= w_grantD & bus.d_we;
                end
            end

            if (r_state == ST_BUSY) begin
                if (r_cnt == 4'd0) begin
                    if (r_portD) begin
                        r_dAck   <= 1'b1;
                        r_dErr   <= 1'b0;
                        r_dRdata <= bus.mem_rdata;
                    end else begin
                        r_iAck   <= 1'b1;
                        r_iErr   <= 1'b0;
                        r_iRdata <= bus.mem_rdata;
                    end
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    assign bus.i_ack     = r_iAck;
    assign bus.i_err     = r_iErr;
    assign bus.i_rdata   = r_iRdata;
    assign bus.d_ack     = r_dAck;
    assign bus.d_err     = r_dErr;
    assign bus.d_rdata   = r_dRdata;
    assign bus.mem_en    = r_memEn;
    assign bus.mem_we    = r_memWe;
    assign bus.mem_addr  = r_memAddr;
    assign bus.mem_wdata = r_memWdata;
    assign bus.stall     = (bus.i_req & ~bus.i_ack) | (bus.d_req & ~bus.d_ack);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: five instances (WAIT/ADDR_W variants), each with its own
// memory model that returns 0xDEAD until the read data is due.
module tb_mem_arbiter;
    localparam int NI = 5;
    localparam int WAITS [NI] = '{1, 1, 0, 3, 15};
    localparam int AWS   [NI] = '{8, 4, 8, 8, 8};

    logic        clk = 1'b0;
    logic        reset;
    logic        iReq [NI];
    logic        dReq [NI];
    logic        dWe;
    logic [15:0] iAddr;
    logic [15:0] dAddr;
    logic [15:0] dWdata;

    logic        iAck  [NI];
    logic        iErr  [NI];
    logic        dAck  [NI];
    logic        dErr  [NI];
    logic        stall [NI];
    logic        memEn [NI];
    logic        memWe [NI];
    logic [15:0] iRdata   [NI];
    logic [15:0] dRdata   [NI];
    logic [15:0] memWdata [NI];
    logic [7:0]  memAddr  [NI];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : gInst
        localparam int AW = AWS[g];
        localparam int WT = WAITS[g];

        mem_arbiter_if #(.n(16), .ADDR_W(AW)) bus ();
        logic [15:0] mem [2**AW];
        logic [15:0] rdHold;
        logic [4:0]  age;

        assign bus.i_req   = iReq[g];
        assign bus.i_addr  = iAddr;
        assign bus.d_req   = dReq[g];
        assign bus.d_we    = dWe;
        assign bus.d_addr  = dAddr;
        assign bus.d_wdata = dWdata;

        assign iAck[g]     = bus.i_ack;
        assign iErr[g]     = bus.i_err;
        assign iRdata[g]   = bus.i_rdata;
        assign dAck[g]     = bus.d_ack;
        assign dErr[g]     = bus.d_err;
        assign dRdata[g]   = bus.d_rdata;
        assign stall[g]    = bus.stall;
        assign memEn[g]    = bus.mem_en;
        assign memWe[g]    = bus.mem_we;
        assign memAddr[g]  = 8'(bus.mem_addr);
        assign memWdata[g] = bus.mem_wdata;

        // Read data appears WT cycles after the strobe cycle and holds until the next strobe
        assign bus.mem_rdata = bus.mem_en ? ((WT == 0) ? mem[bus.mem_addr] : 16'hDEAD)
                                          : ((int'(age) >= WT) ? rdHold : 16'hDEAD);

        always @(posedge clk) begin
            if (!reset) begin
                for (int k = 0; k < 2**AW; k++) mem[k] <= (k == 2) ? 16'hBEEF : 16'(16'h1000 + k);
                rdHold <= 16'h0000;
                age    <= 5'd31;
            end else if (bus.mem_en) begin
                rdHold <= mem[bus.mem_addr];
                age    <= 5'd1;
                if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            end else if (age != 5'd31) begin
                age <= age + 5'd1;
            end
        end

        mem_arbiter #(.n(16), .ADDR_W(AW), .WAIT(WT), .STARVE(4)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input bit isD, input bit we,
                                 input logic [15:0] addr, input logic [15:0] wdata);
        if (isD) begin
            dAddr     = addr;
            dWe       = we;
            dWdata    = wdata;
            dReq[idx] = 1'b1;
        end else begin
            iAddr     = addr;
            iReq[idx] = 1'b1;
        end
    endtask

    // Returns in the ack cycle; lat is the cycle count from the request cycle, -1 on timeout
    task automatic waitAck(input int idx, input bit isD, input int startCyc, output int lat);
        lat = -1;
        for (int c = startCyc; c <= 40; c++) begin
            if ((isD ? dAck[idx] : iAck[idx]) === 1'b1) begin
                lat = c;
                break;
            end
            tick(1);
        end
    endtask

    initial begin
        int          lat;
        int          ackCount;
        int          bothAck;
        int          stallBad;
        int          ackCyc [NI];
        logic [9:0]  order;

        for (int k = 0; k < NI; k++) begin
            iReq[k] = 1'b0;
            dReq[k] = 1'b0;
        end
        dWe    = 1'b0;
        iAddr  = 16'h0000;
        dAddr  = 16'h0000;
        dWdata = 16'h0000;
        reset  = 1'b0;
        tick(3);

        $display("[TB] reset state");
        checkOutput("rst_i_ack", 32'(iAck[0]), 32'd0);
        checkOutput("rst_d_ack", 32'(dAck[0]), 32'd0);
        checkOutput("rst_mem_en", 32'(memEn[0]), 32'd0);
        checkOutput("rst_i_rdata", 32'(iRdata[0]), 32'd0);
        checkOutput("rst_stall", 32'(stall[0]), 32'd0);
        reset = 1'b1;
        tick(1);

        $display("[TB] single fetch WAIT=1");
        applyStimulus(0, 1'b0, 1'b0, 16'h0004, 16'h0000);
        tick(1);
        checkOutput("fetch_c1_mem_en", 32'(memEn[0]), 32'd1);
        checkOutput("fetch_c1_mem_addr", 32'(memAddr[0]), 32'd2);
        checkOutput("fetch_c1_mem_we", 32'(memWe[0]), 32'd0);
        checkOutput("fetch_c1_stall", 32'(stall[0]), 32'd1);
        checkOutput("fetch_c1_i_ack", 32'(iAck[0]), 32'd0);
        tick(1);
        checkOutput("fetch_c2_mem_en", 32'(memEn[0]), 32'd0);
        checkOutput("fetch_c2_i_ack", 32'(iAck[0]), 32'd0);
        tick(1);
        checkOutput("fetch_c3_i_ack", 32'(iAck[0]), 32'd1);
        checkOutput("fetch_c3_i_rdata", 32'(iRdata[0]), 32'hBEEF);
        checkOutput("fetch_c3_i_err", 32'(iErr[0]), 32'd0);
        checkOutput("fetch_c3_stall", 32'(stall[0]), 32'd0);
        iReq[0] = 1'b0;
        tick(1);
        checkOutput("fetch_c4_i_ack", 32'(iAck[0]), 32'd0);

        $display("[TB] store then load");
        applyStimulus(0, 1'b1, 1'b1, 16'h0010, 16'h1234);
        tick(1);
        checkOutput("store_mem_en", 32'(memEn[0]), 32'd1);
        checkOutput("store_mem_we", 32'(memWe[0]), 32'd1);
        checkOutput("store_mem_addr", 32'(memAddr[0]), 32'd8);
        checkOutput("store_mem_wdata", 32'(memWdata[0]), 32'h1234);
        waitAck(0, 1'b1, 1, lat);
        checkOutput("store_latency", 32'(lat), 32'd3);
        dReq[0] = 1'b0;
        dWe     = 1'b0;
        tick(1);
        applyStimulus(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        waitAck(0, 1'b1, 0, lat);
        checkOutput("load_latency", 32'(lat), 32'd3);
        checkOutput("load_d_rdata", 32'(dRdata[0]), 32'h1234);
        checkOutput("load_d_err", 32'(dErr[0]), 32'd0);
        dReq[0] = 1'b0;
        tick(1);

        $display("[TB] misaligned data address");
        applyStimulus(0, 1'b1, 1'b0, 16'h0003, 16'h0000);
        tick(1);
        checkOutput("mis_d_ack", 32'(dAck[0]), 32'd1);
        checkOutput("mis_d_err", 32'(dErr[0]), 32'd1);
        checkOutput("mis_d_rdata", 32'(dRdata[0]), 32'd0);
        checkOutput("mis_mem_en", 32'(memEn[0]), 32'd0);
        dReq[0] = 1'b0;
        tick(1);
        checkOutput("mis_ack_one_cycle", 32'(dAck[0]), 32'd0);
        checkOutput("mis_err_held", 32'(dErr[0]), 32'd1);

        $display("[TB] ADDR_W=4 range check");
        applyStimulus(1, 1'b0, 1'b0, 16'h0020, 16'h0000);
        tick(1);
        checkOutput("range_i_ack", 32'(iAck[1]), 32'd1);
        checkOutput("range_i_err", 32'(iErr[1]), 32'd1);
        checkOutput("range_mem_en", 32'(memEn[1]), 32'd0);
        iReq[1] = 1'b0;
        tick(1);
        applyStimulus(1, 1'b0, 1'b0, 16'h001E, 16'h0000);
        waitAck(1, 1'b0, 0, lat);
        checkOutput("top_word_latency", 32'(lat), 32'd3);
        checkOutput("top_word_i_rdata", 32'(iRdata[1]), 32'h100F);
        checkOutput("top_word_i_err", 32'(iErr[1]), 32'd0);
        checkOutput("top_word_mem_addr", 32'(memAddr[1]), 32'd15);
        iReq[1] = 1'b0;
        tick(1);

        $display("[TB] contention STARVE=4");
        applyStimulus(0, 1'b0, 1'b0, 16'h0004, 16'h0000);
        applyStimulus(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
        ackCount = 0;
        bothAck  = 0;
        order    = '0;
        for (int c = 1; c <= 40; c++) begin
            tick(1);
            if (iAck[0] && dAck[0]) bothAck++;
            if (iAck[0] || dAck[0]) begin
                ackCount++;
                order = {order[8:0], dAck[0]};
            end
        end
        iReq[0] = 1'b0;
        dReq[0] = 1'b0;
        checkOutput("cont_ack_count", 32'(ackCount), 32'd10);
        checkOutput("cont_both_ack", 32'(bothAck), 32'd0);
        checkOutput("cont_order", 32'(order), 32'b1111011110);
        checkOutput("cont_i_rdata", 32'(iRdata[0]), 32'hBEEF);
        checkOutput("cont_d_rdata", 32'(dRdata[0]), 32'h1234);
        tick(1);

        $display("[TB] WAIT sweep 0/3/15");
        for (int k = 2; k < NI; k++) begin
            ackCyc[k] = -1;
            iReq[k]   = 1'b1;
        end
        iAddr    = 16'h0004;
        stallBad = 0;
        #1;
        for (int c = 0; c <= 30; c++) begin
            for (int k = 2; k < NI; k++) begin
                if (ackCyc[k] < 0) begin
                    if (iAck[k] === 1'b1) begin
                        ackCyc[k] = c;
                        if (stall[k] !== 1'b0) stallBad++;
                        iReq[k] = 1'b0;
                    end else if (stall[k] !== 1'b1) begin
                        stallBad++;
                    end
                end
            end
            tick(1);
        end
        checkOutput("wait0_latency", 32'(ackCyc[2]), 32'd2);
        checkOutput("wait3_latency", 32'(ackCyc[3]), 32'd5);
        checkOutput("wait15_latency", 32'(ackCyc[4]), 32'd17);
        checkOutput("wait0_rdata", 32'(iRdata[2]), 32'hBEEF);
        checkOutput("wait3_rdata", 32'(iRdata[3]), 32'hBEEF);
        checkOutput("wait15_rdata", 32'(iRdata[4]), 32'hBEEF);
        checkOutput("sweep_stall", 32'(stallBad), 32'd0);

        $display("[TB] reset mid-BUSY");
        applyStimulus(0, 1'b1, 1'b1, 16'h0010, 16'h5555);
        tick(1);
        checkOutput("prerst_mem_en", 32'(memEn[0]), 32'd1);
        reset   = 1'b0;
        dReq[0] = 1'b0;
        dWe     = 1'b0;
        #1;
        checkOutput("rst_now_mem_en", 32'(memEn[0]), 32'd0);
        checkOutput("rst_now_mem_we", 32'(memWe[0]), 32'd0);
        checkOutput("rst_now_mem_addr", 32'(memAddr[0]), 32'd0);
        checkOutput("rst_now_mem_wdata", 32'(memWdata[0]), 32'd0);
        checkOutput("rst_now_i_rdata", 32'(iRdata[0]), 32'd0);
        checkOutput("rst_now_d_rdata", 32'(dRdata[0]), 32'd0);
        checkOutput("rst_now_stall", 32'(stall[0]), 32'd0);
        tick(2);
        checkOutput("rst_no_d_ack", 32'(dAck[0]), 32'd0);
        reset = 1'b1;
        tick(1);
        applyStimulus(0, 1'b0, 1'b0, 16'h0004, 16'h0000);
        waitAck(0, 1'b0, 0, lat);
        checkOutput("post_rst_latency", 32'(lat), 32'd3);
        checkOutput("post_rst_i_rdata", 32'(iRdata[0]), 32'hBEEF);
        iReq[0] = 1'b0;
        tick(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
